reg_bank_multiport: RTL
=======================

REG_BANK_MULTIPORT -- requirements
Module: reg_bank_multiport

Interface
REQ-001 Parameter WIDTH, default 64: register data width in bits.
REQ-002 Parameter NUM_READ, default 2: number of read ports, range 1..4.
REQ-003 Parameter NUM_WRITE, default 2: number of write ports, range 1..2.
REQ-004 clk  input  1: single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1: reset, synchronous and active-low.
REQ-006 readAddr  input  NUM_READ*5: packed read addresses; port i occupies bits [5i+4:5i].
REQ-007 readData  output  NUM_READ*WIDTH: packed read data; port i occupies bits [WIDTH*i+WIDTH-1:WIDTH*i].
REQ-008 writeAddr  input  NUM_WRITE*5: packed write addresses.
REQ-009 writeData  input  NUM_WRITE*WIDTH: packed write data.
REQ-010 regWrite  input  NUM_WRITE: per-port write enable.
REQ-011 clearReq  input  1: request to zero all registers.
REQ-012 busy  output  1: high while the clear sequencer runs.
REQ-013 clearDone  output  1: one-cycle pulse on the cycle after the final clear write.

Function
REQ-014 The storage SHALL be 31 registers X0..X30 of WIDTH bits; address 31 (XZR) SHALL have no storage.
REQ-015 A read of address 31 SHALL return all zeros on every port.
REQ-016 Writes to address 31 SHALL be discarded.
REQ-017 Reads SHALL be combinational from storage, with zero clock latency.
REQ-018 In IDLE, a port with regWrite[j]=1 SHALL update its target register at the rising edge.
REQ-019 When both write ports target the same address in one cycle, port 1 SHALL win.
REQ-020 The sequencer SHALL have states IDLE and CLEAR, with a 5-bit index counter.
REQ-021 IDLE -> CLEAR on clearReq=1; the counter SHALL load 0.
REQ-022 In CLEAR, register[index] SHALL be zeroed each cycle and the index incremented.
REQ-023 CLEAR -> IDLE after index 30 is written, 31 cycles in total; clearDone SHALL pulse in the first IDLE cycle.
REQ-024 In CLEAR, busy SHALL be 1, all regWrite SHALL be ignored, and all readData SHALL return 0.
REQ-025 clearReq asserted during CLEAR SHALL be ignored and SHALL not restart the count.
REQ-026 clearReq and regWrite asserted together in IDLE: the write SHALL be dropped and CLEAR SHALL be entered.

Reset
REQ-027 rst_n=0 at a rising edge SHALL force the state to CLEAR, the index to 0, and clearDone to 0.
REQ-028 busy SHALL be 1 while rst_n=0 and on the cycle after release.
REQ-029 After reset release, the sequencer SHALL zero all registers with no clearReq needed.
REQ-030 Reset asserted mid-CLEAR SHALL restart the clear from index 0.

Configuration
REQ-031 Macro REG_BANK_BYPASS_EN, when defined, SHALL forward same-cycle write data to any read port whose address matches an enabled write in IDLE.
REQ-032 The forwarded value SHALL come from the winning port per REQ-019; address 31 is never forwarded.
REQ-033 Without REG_BANK_BYPASS_EN, a read SHALL return the pre-edge stored value, and new data SHALL be visible the cycle after the write edge.

Structure
REQ-034 A shared package reg_bank_pkg SHALL hold REG_ADDR_W=5, XZR_ADDR=31, NUM_ARCH_REGS=31, and the state enum {IDLE, CLEAR}.
REQ-035 The clear sequencer (FSM, counter, busy, clearDone) SHALL be sub-module reg_bank_clear_seq.
REQ-036 The storage array, write arbitration, and read muxes SHALL stay in reg_bank_multiport.

Verification
REQ-037 Reset -> busy=1 for 31 cycles after release, clearDone pulses once, then every read returns 0.
REQ-038 Write X5=0xDEADBEEF_00000001 on port 0 -> next cycle, readAddr=5 on both read ports returns 0xDEADBEEF_00000001.
REQ-039 Ports 0 and 1 both write X7, with 0x11 and 0x22 -> X7 reads 0x22.
REQ-040 Write X31=0xFFFF -> X31 reads 0; X0..X30 are unchanged.
REQ-041 Write X3=0xAA while reading X3 in the same cycle -> returns 0xAA with REG_BANK_BYPASS_EN, old value without it.
REQ-042 Assert rst_n=0 at clear index 12 -> after release, 31 further busy cycles and a single clearDone pulse.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the multiport register bank and its clear sequencer.
package reg_bank_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int NUM_ARCH_REGS = 31;

  // Address 31 is the zero register: reads return 0, writes vanish.
  localparam logic [REG_ADDR_W-1:0] XZR_ADDR = 5'd31;

  // Index of the last architectural register touched by the clear sweep.
  localparam logic [REG_ADDR_W-1:0] LAST_IDX = 5'(NUM_ARCH_REGS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } seq_state_e;

endpackage

// File: rtl/reg_bank_clear_seq.sv
// Clear sequencer: walks X0..X30 writing zero, one register per cycle.
// Entered from reset or from a clear request; pulses clear_done_o once the
// last register has been written.
module reg_bank_clear_seq
  import reg_bank_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_req_i,
  output logic                  busy_o,
  output logic                  clear_done_o,
  output logic                  clear_we_o,
  output logic [REG_ADDR_W-1:0] clear_idx_o
);

  seq_state_e            state_q, state_d;
  logic [REG_ADDR_W-1:0] idx_q, idx_d;
  logic                  done_q, done_d;

  // State, index and done-pulse registers; reset restarts a full sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; a request arriving mid-sweep is deliberately ignored.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req_i) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      default: begin
        state_d = CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  // Busy also covers the reset interval itself, before the state settles.
  assign busy_o       = (state_q == CLEAR) || !rst_n;
  assign clear_we_o   = (state_q == CLEAR) && rst_n;
  assign clear_idx_o  = idx_q;
  assign clear_done_o = done_q;

endmodule

// File: rtl/reg_bank_multiport.sv
// Multiport register bank: 31 x WIDTH storage plus a hard-wired zero at
// address 31, NUM_READ combinational read ports, NUM_WRITE write ports
// (higher port index wins on address collision) and a clear sequencer.
// Optional macro REG_BANK_BYPASS_EN forwards same-cycle write data to reads.
module reg_bank_multiport
  import reg_bank_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_READ*REG_ADDR_W-1:0] readAddr,
  output logic [NUM_READ*WIDTH-1:0]      readData,
  input  logic [NUM_WRITE*REG_ADDR_W-1:0] writeAddr,
  input  logic [NUM_WRITE*WIDTH-1:0]     writeData,
  input  logic [NUM_WRITE-1:0]           regWrite,
  input  logic                           clearReq,
  output logic                           busy,
  output logic                           clearDone
);

  logic                  seq_busy;
  logic                  clear_we;
  logic [REG_ADDR_W-1:0] clear_idx;
  logic [NUM_WRITE-1:0]  wr_en;

  logic [WIDTH-1:0] regs_q [NUM_ARCH_REGS];

  reg_bank_clear_seq u_clear_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_req_i  (clearReq),
    .busy_o       (seq_busy),
    .clear_done_o (clearDone),
    .clear_we_o   (clear_we),
    .clear_idx_o  (clear_idx)
  );

  assign busy = seq_busy;

  // A write lands only when idle, not overridden by a clear request, and
  // not aimed at the zero register.
  for (genvar gi = 0; gi < NUM_WRITE; gi++) begin : g_wr_en
    assign wr_en[gi] = regWrite[gi] && !seq_busy && !clearReq &&
                       (writeAddr[gi*REG_ADDR_W +: REG_ADDR_W] != XZR_ADDR);
  end

  // Storage update: clear sweep, else writes in port order so the last port wins.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      regs_q[clear_idx] <= '0;
    end else begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (wr_en[j]) begin
          regs_q[writeAddr[j*REG_ADDR_W +: REG_ADDR_W]] <= writeData[j*WIDTH +: WIDTH];
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
    logic [REG_ADDR_W-1:0] raddr;
    logic [WIDTH-1:0]      rdata;

    assign raddr = readAddr[gi*REG_ADDR_W +: REG_ADDR_W];

    // Read mux: zero while clearing or for XZR, otherwise stored (or forwarded) data.
    always_comb begin
      rdata = '0;
      if (!seq_busy && (raddr != XZR_ADDR)) begin
        rdata = regs_q[raddr];
`ifdef REG_BANK_BYPASS_EN
        for (int j = 0; j < NUM_WRITE; j++) begin
          if (wr_en[j] && (writeAddr[j*REG_ADDR_W +: REG_ADDR_W] == raddr)) begin
            rdata = writeData[j*WIDTH +: WIDTH];
          end
        end
`endif
      end
    end

    assign readData[gi*WIDTH +: WIDTH] = rdata;
  end

endmodule
